// File: rtl/b1_sweep_ctrl_if.sv
// Sweep controller bus: vector drive, benchmark outputs, status and results.
// master = controller side, slave = harness side.
interface b1_sweep_ctrl_if #(
  parameter int NI = 3,
  parameter int NO = 4
);
  logic             start;
  logic             abort;
  logic [NI-1:0]    pi;
  logic [NO-1:0]    po_exact;
  logic [NO-1:0]    po_apx;
  logic             busy;
  logic             done;
  logic [NI:0]      err_cnt;
  logic [NO-1:0]    max_ae;
  logic [NO+NI-1:0] sum_ae;

  modport master (
    input  start, abort,
    input  po_exact, po_apx,
    output pi, busy, done,
    output err_cnt, max_ae, sum_ae
  );

  modport slave (
    output start, abort,
    output po_exact, po_apx,
    input  pi, busy, done,
    input  err_cnt, max_ae, sum_ae
  );
endinterface

// File: rtl/b1_sweep_ctrl.sv
// Exhaustive input sweep over an exact/approximate benchmark pair,
// accumulating mismatch count, max and sum of absolute error.
module b1_sweep_ctrl #(
  parameter int NI     = 3,
  parameter int NO     = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  b1_sweep_ctrl_if.master bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  localparam logic [NI-1:0] PI_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NI-1:0]    r_pi;
  logic [CW-1:0]    r_cnt;
  logic [NI:0]      r_err_cnt;
  logic [NO-1:0]    r_max_ae;
  logic [NO+NI-1:0] r_sum_ae;

  logic          w_go;
  logic          w_last_vec;
  logic [NO-1:0] w_ae;

  assign w_go = bus.start && !bus.abort;
  assign w_last_vec = (r_pi == PI_MAX);

  // Unsigned magnitude without a wider intermediate.
  always_comb begin
    w_ae = '0;
    if (bus.po_exact >= bus.po_apx)
      w_ae = bus.po_exact - bus.po_apx;
    else
      w_ae = bus.po_apx - bus.po_exact;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (bus.abort)
          w_next = S_IDLE;
        else if (r_cnt == LAST)
          w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.abort)
          w_next = S_IDLE;
        else if (w_last_vec)
          w_next = S_DONE;
        else
          w_next = S_DRIVE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pi      <= '0;
      r_cnt     <= '0;
      r_err_cnt <= '0;
      r_max_ae  <= '0;
      r_sum_ae  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_pi      <= '0;
            r_cnt     <= '0;
            r_err_cnt <= '0;
            r_max_ae  <= '0;
            r_sum_ae  <= '0;
          end
        end
        S_DRIVE: begin
          if (bus.abort) begin
            r_pi  <= '0;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          if (bus.abort) begin
            r_pi  <= '0;
            r_cnt <= '0;
          end else begin
            r_err_cnt <= r_err_cnt + (NI+1)'(w_ae != '0);
            r_sum_ae  <= r_sum_ae + (NO+NI)'(w_ae);
            if (w_ae > r_max_ae)
              r_max_ae <= w_ae;
            // Last vector stays on pi after the sweep.
            if (!w_last_vec) begin
              r_pi  <= r_pi + NI'(1);
              r_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pi      = r_pi;
  assign bus.busy    = (r_state == S_DRIVE) ||
                       (r_state == S_SAMPLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.err_cnt = r_err_cnt;
  assign bus.max_ae  = r_max_ae;
  assign bus.sum_ae  = r_sum_ae;

  a_busy_done_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.busy && bus.done)
  );

  a_done_one_cycle: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.done |=> !bus.done
  );

endmodule

// File: tb/tb_b1_sweep_ctrl.sv
// Bench for b1_sweep_ctrl: scoreboard of expected sweep results,
// popped by a monitor on each done pulse.
module tb_b1_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int ec;
    int mx;
    int sm;
    int at;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1e;
  exp_t m2e;

  b1_sweep_ctrl_if #(.NI(3), .NO(4)) b1 ();
  b1_sweep_ctrl_if #(.NI(3), .NO(4)) b2 ();

  b1_sweep_ctrl #(.NI(3), .NO(4), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  b1_sweep_ctrl #(.NI(3), .NO(4), .SETTLE(3)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: apx==exact, 1: apx=0, 2: apx=exact-3 at pi=5
  function automatic logic [3:0] f_apx(
    input int m, input logic [2:0] p, input logic [3:0] e);
    logic [3:0] r;
    r = e;
    if (m == 1) r = 4'd0;
    if (m == 2 && p == 3'd5) r = e - 4'd3;
    return r;
  endfunction

  always_comb begin
    b1.po_exact = {1'b0, b1.pi} + 4'd1;
    b1.po_apx   = f_apx(mode, b1.pi, {1'b0, b1.pi} + 4'd1);
    b2.po_exact = {1'b0, b2.pi} + 4'd1;
    b2.po_apx   = f_apx(mode, b2.pi, {1'b0, b2.pi} + 4'd1);
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (b1.done) begin
      chk("d1_expected", int'(q1.size() != 0), 1);
      chk("d1_busy_excl", int'(b1.busy), 0);
      if (q1.size() != 0) begin
        m1e = q1.pop_front();
        chk("d1_err_cnt", int'(b1.err_cnt), m1e.ec);
        chk("d1_max_ae", int'(b1.max_ae), m1e.mx);
        chk("d1_sum_ae", int'(b1.sum_ae), m1e.sm);
        chk("d1_latency", cyc, m1e.at);
      end
    end
    if (b2.done) begin
      chk("d2_expected", int'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        m2e = q2.pop_front();
        chk("d2_err_cnt", int'(b2.err_cnt), m2e.ec);
        chk("d2_max_ae", int'(b2.max_ae), m2e.mx);
        chk("d2_sum_ae", int'(b2.sum_ae), m2e.sm);
        chk("d2_latency", cyc, m2e.at);
      end
    end
  end

  task automatic wait_q(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 1 && q1.size() == 0) break;
      if (sel == 2 && q2.size() == 0) break;
      step();
    end
    if (sel == 1) begin
      chk("done_timeout1", q1.size(), 0);
      q1.delete();
    end else begin
      chk("done_timeout2", q2.size(), 0);
      q2.delete();
    end
  endtask

  task automatic zero_chk(input string nm);
    chk({nm, "_pi"}, int'(b1.pi), 0);
    chk({nm, "_busy"}, int'(b1.busy), 0);
    chk({nm, "_done"}, int'(b1.done), 0);
    chk({nm, "_err"}, int'(b1.err_cnt), 0);
    chk({nm, "_max"}, int'(b1.max_ae), 0);
    chk({nm, "_sum"}, int'(b1.sum_ae), 0);
  endtask

  task automatic go1();
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    b1.start = 1'b0;
    b1.abort = 1'b0;
    b2.start = 1'b0;
    b2.abort = 1'b0;
    #12;
    zero_chk("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // T1
    mode = 0;
    q1.push_back('{0, 0, 0, cyc + 17});
    go1();
    wait_q(1, 40);

    // T2 with pi trace
    mode = 1;
    q1.push_back('{8, 8, 36, cyc + 17});
    go1();
    for (int k = 1; k <= 16; k++) begin
      chk("t2_pi", int'(b1.pi), (k - 1) / 2);
      chk("t2_busy", int'(b1.busy), 1);
      step();
    end
    wait_q(1, 40);
    chk("t2_pi_hold", int'(b1.pi), 7);

    // T3
    mode = 2;
    q1.push_back('{1, 3, 3, cyc + 17});
    go1();
    wait_q(1, 40);

    // abort beats start in IDLE
    b1.start = 1'b1;
    b1.abort = 1'b1;
    step();
    b1.start = 1'b0;
    b1.abort = 1'b0;
    chk("idle_abort_busy", int'(b1.busy), 0);

    // T4
    mode = 1;
    go1();
    step(5);
    b1.abort = 1'b1;
    step();
    b1.abort = 1'b0;
    chk("t4_busy", int'(b1.busy), 0);
    chk("t4_pi", int'(b1.pi), 0);
    chk("t4_done", int'(b1.done), 0);
    step(20);
    q1.push_back('{8, 8, 36, cyc + 17});
    go1();
    wait_q(1, 40);

    // T5: starts in DRIVE and in DONE are dropped
    q1.push_back('{8, 8, 36, cyc + 17});
    go1();
    step(2);
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    chk("t5_busy", int'(b1.busy), 1);
    step(13);
    chk("t5_in_done", int'(b1.done), 1);
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    chk("t5_idle_busy", int'(b1.busy), 0);
    step(20);
    chk("t5_q_empty", q1.size(), 0);

    // async reset mid-sweep
    go1();
    step(8);
    #2;
    rst_n = 1'b0;
    #1;
    zero_chk("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    chk("arst_stay_idle", int'(b1.busy), 0);

    // T6 on the SETTLE=3 instance
    mode = 1;
    q2.push_back('{8, 8, 36, cyc + 33});
    b2.start = 1'b1;
    step();
    b2.start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk("t6_pi", int'(b2.pi), (k - 1) / 4);
      step();
    end
    wait_q(2, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
